instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Inverse of the processor's instruction decode path: packs op/funct3/funct7/rd/rs1/rs2/imm fields
//  into 32-bit RV32I words (R/I/S/B/U/J formats) and writes them sequentially into instruction memory.
//  Sits between the testbench/host stream and the imem write port. Holds the CPU while a program loads.
// PARAMETERS
//  ADDR_W     6   imem word-address width
//  DEPTH      64  max words per load (<= 2**ADDR_W)
//  BASE_ADDR  0   first word address written after start
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high reset
//  start       in   1       begin a load (honoured in IDLE/DONE only)
//  in_valid    in   1       field bundle valid
//  in_ready    out  1       encoder can accept the bundle
//  fmt         in   3       0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//  op          in   7       opcode
//  funct3      in   3       funct3
//  funct7      in   7       funct7 (R only)
//  rd,rs1,rs2  in   5 each  register indices
//  imm         in   32      signed immediate, byte offset for B/J, full value for U
//  last        in   1       marks final word of the program
//  imem_we     out  1       one-cycle write strobe
//  imem_addr   out  ADDR_W  word address
//  imem_wdata  out  32      encoded instruction
//  cpu_hold    out  1       keep processor in reset/stall
//  busy        out  1       FSM in LOAD
//  done        out  1       load finished
//  err         out  1       sticky error, cleared by start
// BEHAVIOUR
//  - Reset: state IDLE, count=0, imem_we=0, imem_addr=0, imem_wdata=0, in_ready=0, busy=0, done=0,
//    err=0, cpu_hold=1. Reset mid-load aborts; no write occurs in the reset cycle.
//  - FSM IDLE -start-> LOAD (count=0, err=0). LOAD -accept with last-> DONE. LOAD -accept of word
//    DEPTH-1 without last-> DONE with err=1 (overflow). DONE -start-> LOAD. start in LOAD is ignored.
//  - in_ready=1 only in LOAD. Accept = in_valid & in_ready; fields are sampled on that edge.
//  - Latency 1: cycle after accept, imem_we=1, imem_addr=BASE_ADDR+count, imem_wdata=encoding.
//    count increments on accept. Back-to-back accepts give back-to-back writes.
//  - cpu_hold=1 in IDLE and LOAD and =0 in DONE. done=1 in DONE, asserted on the same cycle as the final write.
//  - Encoding:
//    R {funct7,rs2,rs1,funct3,rd,op}
//    I {imm[11:0],rs1,funct3,rd,op}
//    S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
//    B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}
//    U {imm[31:12],rd,op}
//    J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//    Out-of-range imm bits are truncated.
// CONFIGURATION
//  - ENC_CHECK_EN defined: word is still accepted but not written (no imem_we, count still advances)
//    and err is set when any of these holds:
//      fmt 6/7
//      I/S imm outside [-2048,2047]
//      B imm odd or outside 13-bit signed range
//      J imm odd or outside 21-bit signed range
//      U imm[11:0]!=0
//  - ENC_CHECK_EN undefined: no checks, truncation applies, and fmt 6/7 writes NOP 32'h00000013.
// STRUCTURE
//  - Package enc_pkg: FMT_R..FMT_J codes, opcode constants (OP_R=7'b0110011, OP_I=7'b0010011,
//    OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI), NOP word, state encoding.
//  - Sub-module instr_field_packer: purely combinational fmt+fields -> 32-bit word plus range_err.
//    Its outputs are registered in the top level.
// TESTING
//  - Basic load: start, then add x3,x1,x2 (R) and addi x1,x0,5 (I, last) -> writes 0x002081B3 @0,
//    0x00500093 @1, done=1, cpu_hold falls with the last write.
//  - Formats: sw x2,8(x1) -> 0x0020A423; beq x1,x2,+8 -> 0x00208463; jal x1,+16 -> 0x010000EF;
//    lui x5,0x12345000 -> 0x123452B7.
//  - Stall: in_valid toggled 1,0,1 -> exactly 2 writes at consecutive addresses; no strobe in the idle gap.
//  - Overflow: DEPTH=4, feed 5 words with no last -> 4 writes, then DONE with err=1 and in_ready=0.
//  - Reset mid-load after 2 words -> IDLE, imem_we=0, cpu_hold=1; a new start writes from BASE_ADDR.
//  - ENC_CHECK_EN: I imm=4096 -> no write, err=1, next word written at count+1; undefined -> writes 0x00000093-style truncated word.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants for the instruction encoder/loader: format codes,
// RV32I opcodes, the NOP word, FSM state encoding and a range helper.
package enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when v, read as signed, is representable in 'bits' bits:
    // everything above the sign bit must be a copy of it.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer: fmt + fields -> 32-bit word.
// With ENC_CHECK_EN defined, range_err flags illegal formats and immediates
// that do not fit their field; otherwise range_err is tied low, immediates
// are silently truncated and illegal formats produce a NOP.
module instr_field_packer
    import enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_err
);

    // Field placement per format, plus optional legality check
    always_comb begin
        word      = NOP_WORD;
        range_err = 1'b0;
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, op};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, op};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            FMT_U:   word = {imm[31:12], rd, op};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: word = NOP_WORD;
        endcase
`ifdef ENC_CHECK_EN
        case (fmt)
            FMT_R:        range_err = 1'b0;
            FMT_I, FMT_S: range_err = !fits_signed(imm, 12);
            FMT_B:        range_err = imm[0] || !fits_signed(imm, 13);
            FMT_U:        range_err = |imm[11:0];
            FMT_J:        range_err = imm[0] || !fits_signed(imm, 21);
            default:      range_err = 1'b1;
        endcase
`endif
    end

`ifndef ENC_CHECK_EN
    // imm[0] only matters to the alignment check; B/J drop it by construction
    logic unused_imm0;
    assign unused_imm0 = imm[0];
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts encoded-field bundles from a host stream, packs
// them into RV32I words and writes them sequentially into imem, holding the
// CPU until the load completes. Optional field checking via ENC_CHECK_EN
// (handled inside instr_field_packer; range_err is always 0 without it).
module instr_encoder_loader
    import enc_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      word;
    logic             range_err;
    logic             accept;
    logic             final_word;

    instr_field_packer u_packer (
        .fmt       (fmt),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .word      (word),
        .range_err (range_err)
    );

    assign accept     = in_valid && in_ready;
    // Either the host says so, or this is the last slot we have room for
    assign final_word = last || (count == CNT_W'(DEPTH - 1));

    // Load FSM; all status outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        count    <= '0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        // A rejected word still consumes its slot
                        count <= count + 1'b1;
                        if (range_err) begin
                            err <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
                            imem_wdata <= word;
                        end
                        if (final_word) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            if (!last) err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (DEPTH=4 so overflow is reachable).
// The driver pushes each expected imem write; a monitor pops on every strobe.
module tb_instr_encoder_loader;
    import enc_pkg::*;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_ready, last;
    logic [2:0]        fmt, funct3;
    logic [6:0]        op, funct7;
    logic [4:0]        rd, rs1, rs2;
    logic [31:0]       imm;
    logic              imem_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .last(last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h, none expected", imem_addr, imem_wdata);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                    chk("wr_data", imem_wdata, e.data);
                    chk("wr_done", 32'(done), 32'(e.done));
                    chk("wr_hold", 32'(cpu_hold), 32'(!e.done));
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        exp_cnt = 0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_err", 32'(err), 32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
    endtask

    // Drive one bundle; wr=0 means the word is expected to be suppressed
    task automatic send(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im, input logic lst,
                        input logic wr, input logic [31:0] exp_word);
        exp_t e;
        int   n;
        @(negedge clk);
        fmt = f; op = o; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2;
        imm = im; last = lst; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (wr) begin
                e.addr = ADDR_W'(exp_cnt);
                e.data = exp_word;
                e.done = lst || (exp_cnt == DEPTH - 1);
                q.push_back(e);
            end
            exp_cnt++;
            @(posedge clk);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
        fmt = '0; op = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Basic load: add x3,x1,x2 ; addi x1,x0,5 (last)
        do_start();
        send(FMT_R, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        send(FMT_I, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
        drop_valid();
        @(negedge clk);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_hold", 32'(cpu_hold), 32'd0);
        chk("basic_ready", 32'(in_ready), 32'd0);
        chk("basic_err", 32'(err), 32'd0);

        // Formats: sw, beq, jal, lui
        do_start();
        send(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020A423);
        send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h00208463);
        send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 1'b1, 32'h010000EF);
        send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b1, 32'h123452B7);
        drop_valid();

        // Negative immediates: addi -1, sw -4, bne -4, jal -8
        do_start();
        send(FMT_I, OP_I, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, -32'sd1, 1'b0, 1'b1, 32'hFFF08093);
        send(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 1'b1, 32'hFE20AE23);
        send(FMT_B, OP_BRANCH, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0, 1'b1, 32'hFE209EE3);
        send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd8, 1'b1, 1'b1, 32'hFF9FF06F);
        drop_valid();

        // lw x5,4(x1) then an illegal format
        do_start();
        send(FMT_I, OP_LOAD, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 32'd4, 1'b0, 1'b1, 32'h0040A283);
`ifdef ENC_CHECK_EN
        send(3'd6, OP_R, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b0, 32'h0);
        drop_valid();
        @(negedge clk);
        chk("fmt6_err", 32'(err), 32'd1);
`else
        send(3'd6, OP_R, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b1, NOP_WORD);
        drop_valid();
        @(negedge clk);
        chk("fmt6_err", 32'(err), 32'd0);
`endif

        // Stall: valid 1,0,1 -> two consecutive writes, nothing in the gap
        do_start();
        send(FMT_R, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        drop_valid();
        send(FMT_I, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b1, 32'h00500093);
        drop_valid();

        // Overflow: 4 words without last fill DEPTH, the 5th is refused
        do_start();
        for (int i = 0; i < DEPTH; i++)
            send(FMT_I, OP_I, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i),
                 1'b0, 1'b1, {12'(i), 5'd0, 3'd0, 5'(i + 1), OP_I});
        @(negedge clk);
        in_valid = 1'b1;
        last     = 1'b0;
        chk("ovf_ready", 32'(in_ready), 32'd0);
        chk("ovf_done", 32'(done), 32'd1);
        chk("ovf_err", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_busy", 32'(busy), 32'd0);

        // Reset mid-load: start clears err, two words, then reset with a word pending
        do_start();
        send(FMT_R, OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
        send(FMT_I, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
        @(negedge clk);
        in_valid = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        do_start();
        send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b1, 32'h123452B7);
        drop_valid();

        // Out-of-range I immediate, followed by a normal word at the next slot
        do_start();
`ifdef ENC_CHECK_EN
        send(FMT_I, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 1'b0, 32'h0);
`else
        send(FMT_I, OP_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 1'b1, 32'h00000093);
`endif
        send(FMT_I, OP_I, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b1, 1'b1, 32'h00100113);
        drop_valid();
        @(negedge clk);
`ifdef ENC_CHECK_EN
        chk("range_err", 32'(err), 32'd1);
`else
        chk("range_err", 32'(err), 32'd0);
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence wedges
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
